// File: rtl/high_score_reader.sv
// rtl/high_score_reader.sv - scans the score RAM for the highest score and presents it as BCD digits
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start             one-cycle pulse from the shaped high-score button
//   ram_gnt           access controller grants the shared RAM port to this block
//   ram_rdata         RAM read data, valid READ_LAT cycles after ram_addr
//   ram_req           request for the RAM port (held through REQ/SCAN/DRAIN)
//   ram_addr          RAM read address, 0 whenever ram_req is low or no read is issued
//   busy              high in every state except IDLE
//   done              one-cycle pulse coincident with the first cycle of an updated result
//   hs_valid          result registers hold a completed scan
//   hs_addr           slot holding the maximum score (lowest slot on ties)
//   hs_hund/tens/ones BCD digits of the maximum score
//
// Build option: define HS_LEADING_BLANK_EN to load leading-zero hundreds/tens digits
// as 4'hF, the blank code understood by the seven-segment driver.

module high_score_reader #(
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ram_gnt,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              busy,
    output logic              done,
    output logic              hs_valid,
    output logic [ADDR_W-1:0] hs_addr,
    output logic [3:0]        hs_hund,
    output logic [3:0]        hs_tens,
    output logic [3:0]        hs_ones
);

    localparam int BCD_W     = 12;
    localparam int STEP_MAX  = (DATA_W > READ_LAT) ? DATA_W : READ_LAT;
    localparam int STEP_W    = $clog2(STEP_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SCAN,
        S_DRAIN,
        S_CONV,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]       addr_cnt;
    logic [STEP_W-1:0]       step_cnt;
    logic [READ_LAT-1:0]     vld_sr;
    logic [ADDR_W-1:0]       tag_sr [READ_LAT];
    logic [DATA_W-1:0]       max_val;
    logic [ADDR_W-1:0]       max_addr;
    // Double-dabble working register: BCD digits above the binary operand.
    logic [BCD_W+DATA_W-1:0] dd_sr;
    logic [BCD_W+DATA_W-1:0] dd_adj;

    logic scanning;
    logic abort;
    logic issue;
    logic cmp_hit;

    logic [3:0] raw_hund, raw_tens, raw_ones;
    logic [3:0] disp_hund, disp_tens;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (r[d*4 +: 4] >= 4'd5) begin
                r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign scanning = (state == S_SCAN) || (state == S_DRAIN);
    // Losing the grant mid-scan invalidates everything gathered so far.
    assign abort    = scanning && !ram_gnt;
    assign issue    = (state == S_SCAN) && ram_gnt;
    // Strict greater-than keeps the lowest address on ties.
    assign cmp_hit  = scanning && ram_gnt && vld_sr[READ_LAT-1] && (ram_rdata > max_val);
    assign busy     = (state != S_IDLE);

    assign dd_adj   = {add3(dd_sr[DATA_W +: BCD_W]), dd_sr[DATA_W-1:0]};

    assign raw_hund = dd_sr[DATA_W+8 +: 4];
    assign raw_tens = dd_sr[DATA_W+4 +: 4];
    assign raw_ones = dd_sr[DATA_W   +: 4];

`ifdef HS_LEADING_BLANK_EN
    always_comb begin
        disp_hund = raw_hund;
        disp_tens = raw_tens;
        if (raw_hund == 4'd0) begin
            disp_hund = 4'hF;
            if (raw_tens == 4'd0) begin
                disp_tens = 4'hF;
            end
        end
    end
`else
    assign disp_hund = raw_hund;
    assign disp_tens = raw_tens;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ram_req    = 1'b0;
        ram_addr   = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                ram_req = 1'b1;
                if (ram_gnt) begin
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                ram_req  = 1'b1;
                ram_addr = addr_cnt;
                if (!ram_gnt) begin
                    state_next = S_REQ;
                end else if (addr_cnt == LAST_ADDR) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                ram_req = 1'b1;
                if (!ram_gnt) begin
                    state_next = S_REQ;
                end else if (step_cnt == STEP_W'(READ_LAT - 1)) begin
                    state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (step_cnt == STEP_W'(DATA_W - 1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= '0;
            step_cnt <= '0;
            vld_sr   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                tag_sr[i] <= '0;
            end
            max_val  <= '0;
            max_addr <= '0;
            dd_sr    <= '0;
            done     <= 1'b0;
            hs_valid <= 1'b0;
            hs_addr  <= '0;
            hs_hund  <= '0;
            hs_tens  <= '0;
            hs_ones  <= '0;
        end else begin
            done <= (state == S_DONE);

            // Address counter: restart at 0 on every entry into SCAN.
            if (state == S_REQ) begin
                addr_cnt <= '0;
            end else if (issue) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end

            // Step counter times DRAIN and CONV; it restarts on every state change.
            if (state_next != state) begin
                step_cnt <= '0;
            end else if ((state == S_DRAIN) || (state == S_CONV)) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end

            // Read-latency tag pipeline: each issued address travels with its valid bit.
            vld_sr[0] <= issue;
            tag_sr[0] <= addr_cnt;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                tag_sr[i] <= tag_sr[i-1];
            end

            if (cmp_hit) begin
                max_val  <= ram_rdata;
                max_addr <= tag_sr[READ_LAT-1];
            end

            if (abort || ((state == S_IDLE) && start)) begin
                vld_sr   <= '0;
                max_val  <= '0;
                max_addr <= '0;
            end

            // The final compare lands on the DRAIN->CONV edge, so seed from the
            // post-compare maximum.
            if ((state == S_DRAIN) && (state_next == S_CONV)) begin
                dd_sr <= {{BCD_W{1'b0}}, (cmp_hit ? ram_rdata : max_val)};
            end else if (state == S_CONV) begin
                dd_sr <= dd_adj << 1;
            end

            if (state == S_DONE) begin
                hs_valid <= 1'b1;
                hs_addr  <= max_addr;
                hs_hund  <= disp_hund;
                hs_tens  <= disp_tens;
                hs_ones  <= raw_ones;
            end
        end
    end

endmodule

// File: doc/high_score_reader.md
Name: high_score_reader

Overview:
Read-side client of the score RAM. The access controller writes per-player scores into this RAM; this block scans every slot and finds the maximum score and its slot address. It converts that score to three BCD digits for the Seven_Seg displays when the shaped high-score button is pressed. A req/gnt handshake lets the access controller retain priority over the single RAM address/data port.

Parameters:
ADDR_W, 3, RAM address width
DEPTH, 8, number of score slots scanned (addresses 0..DEPTH-1)
DATA_W, 8, score width; BCD conversion sized for up to 3 digits
READ_LAT, 1, RAM read latency in clocks (address to SCORE_out valid)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse from shaped high-score button
ram_gnt  input  1  access controller grants RAM port to this block
ram_rdata  input  DATA_W  RAM read data (SCORE_out)
ram_req  output  1  request for RAM port
ram_addr  output  ADDR_W  RAM read address
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when result is updated
hs_valid  output  1  result registers hold a completed scan
hs_addr  output  ADDR_W  slot holding the maximum score
hs_hund, hs_tens, hs_ones  output  4 each  BCD digits of the maximum score

Behaviour:
- Reset is asynchronous, active-high. All outputs reset to 0. State resets to IDLE.
- States: IDLE, REQ, SCAN, DRAIN, CONV, DONE.
- IDLE: start=1 clears the max and addr accumulators and enters REQ. A start pulse in any other state is ignored.
- REQ: ram_req=1. Waits for ram_gnt=1, then enters SCAN with the address counter at 0.
- SCAN: ram_req=1. ram_addr increments by 1 each cycle from 0 to DEPTH-1. A READ_LAT-deep valid shift register tags each issued address. Returned data is compared when its tag emerges. After DEPTH-1 is issued, enter DRAIN.
- DRAIN: ram_req=1. Lasts READ_LAT cycles to capture in-flight reads, then ram_req=0 and enter CONV.
- Compare rule: unsigned; update only when data > current max. Ties keep the lowest address. If all slots are 0, the result is max=0, addr=0.
- Grant loss: if ram_gnt falls during SCAN or DRAIN, in-flight data is discarded, the accumulators are cleared, and the state returns to REQ. The rescan starts from address 0.
- CONV: shift-add-3 (double-dabble) over DATA_W cycles, one bit per cycle, on the captured max.
- DONE: one cycle. Loads hs_hund/tens/ones and hs_addr together, sets hs_valid=1, pulses done=1, then returns to IDLE.
- Result outputs and hs_valid hold their values until the next DONE. They are not cleared by a new start.
- Latency with ram_gnt high throughout: done pulses DEPTH+READ_LAT+DATA_W+2 cycles after the start-sampling edge (19 cycles with defaults).
- ram_addr is 0 whenever ram_req=0.
- Reset mid-operation: immediate return to IDLE; outputs are zeroed, including a previously valid result.
- Max BCD value 255 (DATA_W=8): hundreds digit ≤2.

Optional Feature:
Macro HS_LEADING_BLANK_EN.
- Defined: at DONE, a leading-zero hundreds digit is loaded as 4'hF (blank code). A leading-zero tens digit is also loaded as 4'hF when the hundreds digit is blank. The ones digit is never blanked. Seven_Seg shows 4'hF as all segments off.
- Undefined: digits are always plain BCD 0-9.

Test Plan:
1. RAM {5,200,17,200,0,99,3,42}, gnt held high, pulse start → done at cycle 19; hs=2,0,0; hs_addr=1 (tie keeps lowest); hs_valid=1.
2. RAM all 0 → hs=0,0,0, hs_addr=0. With HS_LEADING_BLANK_EN → hs_hund=F, hs_tens=F, hs_ones=0.
3. RAM {0,...,0,255 at addr 7} → hs=2,5,5, hs_addr=7. Then RAM {9 at addr 2, rest 0}, rescan → hs=0,0,9, addr 2 (F,F,9 with macro).
4. gnt withheld 5 cycles after start → ram_req=1 and ram_addr=0 throughout the wait; done at cycle 24. Also: gnt dropped for 2 cycles when ram_addr=4 → rescan from 0, result identical to test 1, done 2+5 cycles later.
5. start pulsed again at cycle 3 of a scan → ignored; only one done pulse.
6. rst asserted during CONV → same cycle all outputs 0 and busy=0. Next start performs a full scan with correct result.
